fft_peak_det: RTL and testbench



---
 rtl/fft_peak_det.sv | 163 ++++++++++++++++
 tb/tb_fft_peak_det.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_det.sv
// fft_peak_det: per-bin power |Y|^2 stream and per-frame peak bin report for
// the 256-point FFT output stream.
// Optional feature macro FFT_PEAK_THRESH_EN: adds pwr_thresh input and
// registered peak_over output (peak_pwr > pwr_thresh).
module fft_peak_det #(
    parameter int unsigned N    = 256,
    parameter int unsigned LOGN = 8,
    parameter int unsigned DW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              sop_in,
    input  logic [DW-1:0]     y_re,
    input  logic [DW-1:0]     y_im,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [2*DW-1:0]   pwr_thresh,
    output logic              peak_over,
`endif
    output logic              pwr_valid,
    output logic [2*DW-1:0]   pwr_out,
    output logic [LOGN-1:0]   pwr_idx,
    output logic              peak_valid,
    output logic [LOGN-1:0]   peak_idx,
    output logic [2*DW-1:0]   peak_pwr,
    output logic              frame_err
);

    localparam logic [LOGN-1:0] LAST_BIN = LOGN'(N - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state;
    logic [LOGN-1:0]        bin_cnt;

    logic                   acc;
    logic [LOGN-1:0]        acc_idx;

    logic                   s0_vld;
    logic [LOGN-1:0]        s0_idx;
    logic signed [DW-1:0]   s0_re;
    logic signed [DW-1:0]   s0_im;

    logic                   s1_vld;
    logic [LOGN-1:0]        s1_idx;
    logic [2*DW-2:0]        sq_re;
    logic [2*DW-2:0]        sq_im;

    logic signed [2*DW-1:0] re_ext;
    logic signed [2*DW-1:0] im_ext;

    logic [LOGN-1:0]        run_idx;
    logic [2*DW-1:0]        run_pwr;
    logic                   take;
    logic [LOGN-1:0]        best_idx;
    logic [2*DW-1:0]        best_pwr;

    // A sample is accepted when it starts a frame or continues an open one;
    // an sop always restarts numbering at bin 0.
    assign acc     = valid_in && (sop_in || (state == ACCUM));
    assign acc_idx = sop_in ? '0 : bin_cnt;

    // Frame FSM: bin counter, frame open/closed, early-sop error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= valid_in && sop_in && (state == ACCUM);
            if (acc) begin
                if (acc_idx == LAST_BIN) begin
                    state   <= IDLE;
                    bin_cnt <= '0;
                end else begin
                    state   <= ACCUM;
                    bin_cnt <= acc_idx + LOGN'(1);
                end
            end
        end
    end

    // Input register: accepted sample and its bin index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_idx <= '0;
            s0_re  <= '0;
            s0_im  <= '0;
        end else begin
            s0_vld <= acc;
            s0_idx <= acc_idx;
            s0_re  <= $signed(y_re);
            s0_im  <= $signed(y_im);
        end
    end

    // Squares are non-negative and at most 2^(2*DW-2), so 2*DW-1 bits hold them exactly.
    assign re_ext = (2*DW)'(s0_re);
    assign im_ext = (2*DW)'(s0_im);

    // Stage 1: component squares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            sq_re  <= '0;
            sq_im  <= '0;
        end else begin
            s1_vld <= s0_vld;
            s1_idx <= s0_idx;
            sq_re  <= (2*DW-1)'(re_ext * re_ext);
            sq_im  <= (2*DW-1)'(im_ext * im_ext);
        end
    end

    // Stage 2: power sum, widened by one bit so full scale cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_valid <= 1'b0;
            pwr_idx   <= '0;
            pwr_out   <= '0;
        end else begin
            pwr_valid <= s1_vld;
            pwr_idx   <= s1_idx;
            pwr_out   <= {1'b0, sq_re} + {1'b0, sq_im};
        end
    end

    // Bin 0 seeds the running max; later bins win only when strictly greater.
    assign take     = (pwr_idx == '0) || (pwr_out > run_pwr);
    assign best_idx = take ? pwr_idx : run_idx;
    assign best_pwr = take ? pwr_out : run_pwr;

    // Peak tracker: running max per frame, separate report registers held until next report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_idx    <= '0;
            run_pwr    <= '0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_pwr   <= '0;
`ifdef FFT_PEAK_THRESH_EN
            peak_over  <= 1'b0;
`endif
        end else begin
            peak_valid <= 1'b0;
            if (pwr_valid) begin
                run_idx <= best_idx;
                run_pwr <= best_pwr;
                if (pwr_idx == LAST_BIN) begin
                    peak_valid <= 1'b1;
                    peak_idx   <= best_idx;
                    peak_pwr   <= best_pwr;
`ifdef FFT_PEAK_THRESH_EN
                    peak_over  <= best_pwr > pwr_thresh;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_det.sv
// Testbench for fft_peak_det: random and directed frames checked against a
// frame-queue reference model (cycle-accurate expectations).
`timescale 1ns/1ps
module tb_fft_peak_det;

    localparam int unsigned N    = 256;
    localparam int unsigned LOGN = 8;
    localparam int unsigned DW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_in;
    logic              sop_in;
    logic [DW-1:0]     y_re;
    logic [DW-1:0]     y_im;
    logic              pwr_valid;
    logic [2*DW-1:0]   pwr_out;
    logic [LOGN-1:0]   pwr_idx;
    logic              peak_valid;
    logic [LOGN-1:0]   peak_idx;
    logic [2*DW-1:0]   peak_pwr;
    logic              frame_err;
`ifdef FFT_PEAK_THRESH_EN
    logic [2*DW-1:0]   pwr_thresh;
    logic              peak_over;
`endif

    fft_peak_det #(.N(N), .LOGN(LOGN), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .sop_in     (sop_in),
        .y_re       (y_re),
        .y_im       (y_im),
`ifdef FFT_PEAK_THRESH_EN
        .pwr_thresh (pwr_thresh),
        .peak_over  (peak_over),
`endif
        .pwr_valid  (pwr_valid),
        .pwr_out    (pwr_out),
        .pwr_idx    (pwr_idx),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_pwr   (peak_pwr),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [LOGN-1:0] idx;
        logic [2*DW-1:0] pwr;
        logic            over;
    } exp_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;

    exp_t   pwr_q[$];
    exp_t   peak_q[$];
    int     err_q[$];
    longint frame_p[$];
    bit     in_frame = 1'b0;
    logic [31:0] thr_m = 32'd999999;

    logic [LOGN-1:0] held_idx  = '0;
    logic [2*DW-1:0] held_pwr  = '0;
    logic            held_over = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Compare all outputs against the expectation queues for the current cycle.
    task automatic monitor();
        exp_t e;
        if (pwr_q.size() > 0 && pwr_q[0].due == cyc) begin
            e = pwr_q.pop_front();
            chk("pwr_valid", 64'(pwr_valid), 64'd1);
            chk("pwr_idx",   64'(pwr_idx),   64'(e.idx));
            chk("pwr_out",   64'(pwr_out),   64'(e.pwr));
        end else begin
            chk("pwr_valid_quiet", 64'(pwr_valid), 64'd0);
        end
        if (peak_q.size() > 0 && peak_q[0].due == cyc) begin
            e = peak_q.pop_front();
            held_idx  = e.idx;
            held_pwr  = e.pwr;
            held_over = e.over;
            chk("peak_valid", 64'(peak_valid), 64'd1);
        end else begin
            chk("peak_valid_quiet", 64'(peak_valid), 64'd0);
        end
        chk("peak_idx", 64'(peak_idx), 64'(held_idx));
        chk("peak_pwr", 64'(peak_pwr), 64'(held_pwr));
`ifdef FFT_PEAK_THRESH_EN
        chk("peak_over", 64'(peak_over), 64'(held_over));
`endif
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            void'(err_q.pop_front());
            chk("frame_err", 64'(frame_err), 64'd1);
        end else begin
            chk("frame_err_quiet", 64'(frame_err), 64'd0);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then update the model.
    task automatic step(input bit v, input bit s, input logic signed [DW-1:0] re,
                        input logic signed [DW-1:0] im);
        longint r, q, p, best;
        int     bi;
        valid_in = v;
        sop_in   = s;
        y_re     = re;
        y_im     = im;
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n && v && (s || in_frame)) begin
            if (s) begin
                if (frame_p.size() > 0) err_q.push_back(cyc);
                frame_p.delete();
                in_frame = 1'b1;
            end
            r = longint'(re);
            q = longint'(im);
            p = r * r + q * q;
            pwr_q.push_back('{cyc + 2, LOGN'(frame_p.size()), 32'(p), 1'b0});
            frame_p.push_back(p);
            if (frame_p.size() == N) begin
                best = frame_p[0];
                bi   = 0;
                for (int i = 1; i < N; i++) begin
                    if (frame_p[i] > best) begin
                        best = frame_p[i];
                        bi   = i;
                    end
                end
                peak_q.push_back('{cyc + 3, LOGN'(bi), 32'(best), best > longint'(thr_m)});
                frame_p.delete();
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    // mode 0: impulse at bin 37; 1: full scale at bin 5; 2: tie at 10/200; 3: random.
    task automatic send(input int mode, input int nbins, input bit gap);
        logic signed [DW-1:0] re, im;
        for (int i = 0; i < nbins; i++) begin
            if (gap && i > 0) idle(1);
            re = '0;
            im = '0;
            case (mode)
                0: if (i == 37) re = 16'sd1000;
                1: begin
                    re = DW'($urandom_range(0, 8000)) - 16'sd4000;
                    im = DW'($urandom_range(0, 8000)) - 16'sd4000;
                    if (i == 5) begin re = -16'sd32768; im = -16'sd32768; end
                end
                2: begin
                    re = DW'($urandom_range(0, 400)) - 16'sd200;
                    im = DW'($urandom_range(0, 400)) - 16'sd200;
                    if (i == 10 || i == 200) begin re = 16'sd300; im = 16'sd400; end
                end
                default: begin
                    re = DW'($urandom);
                    im = DW'($urandom);
                end
            endcase
            step(1'b1, i == 0, re, im);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        #1;
        chk("rst_pwr_valid",  64'(pwr_valid),  64'd0);
        chk("rst_pwr_out",    64'(pwr_out),    64'd0);
        chk("rst_pwr_idx",    64'(pwr_idx),    64'd0);
        chk("rst_peak_valid", 64'(peak_valid), 64'd0);
        chk("rst_peak_idx",   64'(peak_idx),   64'd0);
        chk("rst_peak_pwr",   64'(peak_pwr),   64'd0);
        chk("rst_frame_err",  64'(frame_err),  64'd0);
`ifdef FFT_PEAK_THRESH_EN
        chk("rst_peak_over",  64'(peak_over),  64'd0);
`endif
        pwr_q.delete();
        peak_q.delete();
        err_q.delete();
        frame_p.delete();
        in_frame  = 1'b0;
        held_idx  = '0;
        held_pwr  = '0;
        held_over = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        y_re     = '0;
        y_im     = '0;
`ifdef FFT_PEAK_THRESH_EN
        pwr_thresh = 32'd999999;
`endif
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // stray samples before any sop are ignored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));

        // impulse, contiguous
        send(0, N, 1'b0);
        idle(5);
        chk("impulse_peak_idx", 64'(peak_idx), 64'd37);
        chk("impulse_peak_pwr", 64'(peak_pwr), 64'd1000000);
`ifdef FFT_PEAK_THRESH_EN
        chk("impulse_over_999999", 64'(peak_over), 64'd1);
        pwr_thresh = 32'd1000000;
`endif
        thr_m = 32'd1000000;
        send(0, N, 1'b0);
        idle(5);
`ifdef FFT_PEAK_THRESH_EN
        chk("impulse_over_1000000", 64'(peak_over), 64'd0);
`endif

        // full scale and ties
        send(1, N, 1'b0);
        idle(5);
        chk("fullscale_peak_pwr", 64'(peak_pwr), 64'd2147483648);
        send(2, N, 1'b0);
        idle(5);
        chk("tie_peak_idx", 64'(peak_idx), 64'd10);
        chk("tie_peak_pwr", 64'(peak_pwr), 64'd250000);

        // gapped frame followed back-to-back by a random frame
        send(0, N, 1'b1);
        send(3, N, 1'b0);
        idle(5);

        // early sop at bin 100 aborts, then a full frame
        send(3, 100, 1'b0);
        send(3, N, 1'b0);
        idle(5);

        // reset mid-frame, stray samples, then a full frame
        send(3, 50, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        send(3, N, 1'b1);
        idle(8);

        chk("pending_expectations", 64'(pwr_q.size() + peak_q.size() + err_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
